prbs16_checker: RTL and testbench

//  Downstream consumer of the 16-bit LFSR pattern generator. Takes one 16-bit word per valid

---
 rtl/prbs16_checker.sv | 124 ++++++++++++
 tb/tb_prbs16_checker.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/prbs16_checker.sv
// Self-synchronising checker for the 16-bit Galois LFSR pattern: hunts for a seed,
// verifies a run of correct predictions, then flywheels and counts mispredictions.
module prbs16_checker #(
    parameter logic [15:0] TAPS         = 16'hB400,
    parameter int          LOCK_COUNT   = 4,
    parameter int          UNLOCK_COUNT = 3
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic [15:0] data_in,
    input  logic        data_valid,
    input  logic        clear_cnt,
    output logic        locked,
    output logic        err_pulse,
    output logic [15:0] err_count,
    output logic [1:0]  state_o
);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [7:0] LOCK_TH   = 8'(LOCK_COUNT);
    localparam logic [7:0] UNLOCK_TH = 8'(UNLOCK_COUNT);

    function automatic logic [15:0] lfsr_next(input logic [15:0] x);
        return (x >> 1) ^ (x[0] ? TAPS : 16'h0000);
    endfunction

    state_t      state_q, state_d;
    logic [15:0] pred_q, pred_d;
    logic [7:0]  match_cnt_q, match_cnt_d;
    logic [7:0]  miss_cnt_q, miss_cnt_d;
    logic        locked_q, locked_d;
    logic        err_pulse_q, err_pulse_d;
    logic [15:0] err_count_q, err_count_d;

    always_comb begin
        state_d     = state_q;
        pred_d      = pred_q;
        match_cnt_d = match_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        locked_d    = locked_q;
        err_pulse_d = 1'b0;
        err_count_d = err_count_q;

        if (data_valid) begin
            unique case (state_q)
                HUNT: begin
                    // All-zero is the LFSR lockup value and can never seed a valid stream.
                    if (data_in != 16'h0000) begin
                        pred_d      = lfsr_next(data_in);
                        match_cnt_d = 8'd0;
                        state_d     = VERIFY;
                    end
                end
                VERIFY: begin
                    if (data_in == pred_q) begin
                        match_cnt_d = match_cnt_q + 8'd1;
                        pred_d      = lfsr_next(data_in);
                        if (match_cnt_q + 8'd1 == LOCK_TH) begin
                            state_d    = LOCKED;
                            locked_d   = 1'b1;
                            miss_cnt_d = 8'd0;
                        end
                    end else if (data_in == 16'h0000) begin
                        match_cnt_d = 8'd0;
                        state_d     = HUNT;
                    end else begin
                        pred_d      = lfsr_next(data_in);
                        match_cnt_d = 8'd0;
                    end
                end
                LOCKED: begin
                    // Flywheel: prediction runs from its own state so bit errors cannot reseed it.
                    pred_d = lfsr_next(pred_q);
                    if (data_in == pred_q) begin
                        miss_cnt_d = 8'd0;
                    end else begin
                        err_pulse_d = 1'b1;
                        if (err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
                        miss_cnt_d = miss_cnt_q + 8'd1;
                        if (miss_cnt_q + 8'd1 == UNLOCK_TH) begin
                            state_d     = HUNT;
                            locked_d    = 1'b0;
                            match_cnt_d = 8'd0;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end

        if (clear_cnt) err_count_d = 16'h0000;
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q     <= HUNT;
            pred_q      <= 16'h0000;
            match_cnt_q <= 8'd0;
            miss_cnt_q  <= 8'd0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            err_count_q <= 16'h0000;
        end else begin
            state_q     <= state_d;
            pred_q      <= pred_d;
            match_cnt_q <= match_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
            err_count_q <= err_count_d;
        end
    end

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign err_count = err_count_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_prbs16_checker.sv
// Bench for prbs16_checker: directed vector table, hand-written corner sequences,
// random stream against a reference model, and a saturation run on a second instance.
module tb_prbs16_checker;

    logic        clk = 1'b0;
    logic        n_reset;
    logic [15:0] data_in;
    logic        data_valid, clear_cnt;
    logic        locked, err_pulse;
    logic [15:0] err_count;
    logic [1:0]  state_o;

    logic [15:0] s_data;
    logic        s_valid;
    logic        s_locked, s_pulse;
    logic [15:0] s_count;
    logic [1:0]  s_state;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    prbs16_checker dut (
        .clk(clk), .n_reset(n_reset), .data_in(data_in), .data_valid(data_valid),
        .clear_cnt(clear_cnt), .locked(locked), .err_pulse(err_pulse),
        .err_count(err_count), .state_o(state_o)
    );

    // Long unlock threshold lets the error counter be driven to saturation while staying locked.
    prbs16_checker #(.UNLOCK_COUNT(255)) u_sat (
        .clk(clk), .n_reset(n_reset), .data_in(s_data), .data_valid(s_valid),
        .clear_cnt(1'b0), .locked(s_locked), .err_pulse(s_pulse),
        .err_count(s_count), .state_o(s_state)
    );

    function automatic logic [15:0] nxt(input logic [15:0] x);
        return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input int st, input bit lk, input bit pl, input int cn);
        chk({tag, ".state"}, 32'(state_o), 32'(st));
        chk({tag, ".locked"}, 32'(locked), 32'(lk));
        chk({tag, ".pulse"}, 32'(err_pulse), 32'(pl));
        chk({tag, ".count"}, 32'(err_count), 32'(cn));
    endtask

    // Reference model: mode 0 searching, 1 confirming, 2 tracking.
    int          m_mode, m_good, m_bad_run, m_cnt;
    logic [15:0] m_pred;
    bit          m_pulse;

    task automatic model_reset();
        m_mode = 0; m_good = 0; m_bad_run = 0; m_cnt = 0; m_pred = 0; m_pulse = 0;
    endtask

    task automatic model_step(input bit v, input logic [15:0] d, input bit c);
        m_pulse = 0;
        if (v) begin
            if (m_mode == 0) begin
                if (d != 0) begin m_pred = nxt(d); m_good = 0; m_mode = 1; end
            end else if (m_mode == 1) begin
                if (d == m_pred) begin
                    m_good++;
                    m_pred = nxt(d);
                    if (m_good >= 4) begin m_mode = 2; m_bad_run = 0; end
                end else if (d == 0) begin
                    m_mode = 0; m_good = 0;
                end else begin
                    m_pred = nxt(d); m_good = 0;
                end
            end else begin
                if (d == m_pred) m_bad_run = 0;
                else begin
                    m_pulse = 1;
                    m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
                    m_bad_run++;
                    if (m_bad_run >= 3) begin m_mode = 0; m_good = 0; end
                end
                m_pred = nxt(m_pred);
            end
        end
        if (c) m_cnt = 0;
    endtask

    task automatic drive(input bit v, input logic [15:0] d, input bit c);
        data_valid = v; data_in = d; clear_cnt = c;
        tick();
        model_step(v, d, c);
    endtask

    typedef struct {
        logic        v;
        logic [15:0] d;
        logic        c;
        int          st;
        bit          lk;
        bit          pl;
        int          cnt;
    } vec_t;

    vec_t tbl[13];

    initial begin
        logic [15:0] w, p, src;
        int errs, run;
        bit v, c;
        logic [15:0] d;

        n_reset = 1'b0; data_in = 16'h0; data_valid = 1'b0; clear_cnt = 1'b0;
        s_data = 16'h0; s_valid = 1'b0;
        model_reset();
        tick(); tick();
        check_out("reset", 0, 0, 0, 0);
        n_reset = 1'b1;

        // Lock on the reference stream, one corrupted word, an idle cycle, then three bad words.
        w = 16'hACE1;
        tbl[0] = '{1, w, 0, 1, 0, 0, 0};
        w = nxt(w); tbl[1] = '{1, w, 0, 1, 0, 0, 0};
        w = nxt(w); tbl[2] = '{1, w, 0, 1, 0, 0, 0};
        w = nxt(w); tbl[3] = '{1, w, 0, 1, 0, 0, 0};
        w = nxt(w); tbl[4] = '{1, w, 0, 2, 1, 0, 0};
        w = nxt(w); tbl[5] = '{1, w, 0, 2, 1, 0, 0};
        w = nxt(w); tbl[6] = '{1, 16'hFFFF, 0, 2, 1, 1, 1};
        tbl[7] = '{0, 16'h5555, 0, 2, 1, 0, 1};
        w = nxt(w); tbl[8] = '{1, w, 0, 2, 1, 0, 1};
        w = nxt(w); tbl[9] = '{1, w, 0, 2, 1, 0, 1};
        tbl[10] = '{1, 16'h0000, 0, 2, 1, 1, 2};
        tbl[11] = '{1, 16'h1111, 0, 2, 1, 1, 3};
        tbl[12] = '{1, 16'h2222, 0, 0, 0, 1, 4};
        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].v, tbl[i].d, tbl[i].c);
            check_out($sformatf("vec%0d", i), tbl[i].st, tbl[i].lk, tbl[i].pl, tbl[i].cnt);
        end

        // Zero words never leave HUNT.
        for (int i = 0; i < 4; i++) begin
            drive(1, 16'h0000, 0);
            chk("hunt_zero.state", 32'(state_o), 0);
        end

        // A wrong word in VERIFY restarts the match run.
        drive(1, 16'hACE1, 0);
        drive(1, nxt(16'hACE1), 0);
        drive(1, 16'h1234, 0);
        chk("reseed.state", 32'(state_o), 1);
        w = 16'h1234;
        for (int i = 0; i < 4; i++) begin
            w = nxt(w);
            drive(1, w, 0);
            chk($sformatf("relock%0d.locked", i), 32'(locked), (i == 3) ? 1 : 0);
        end
        p = nxt(w);

        // Clear wins over a simultaneous increment, but the pulse still fires.
        drive(1, ~p, 1);
        p = nxt(p);
        check_out("clear_err", 2, 1, 1, 0);
        drive(0, 16'h0, 0);
        chk("idle.pulse", 32'(err_pulse), 0);

        // Asynchronous reset while locked with a pulse outstanding.
        drive(1, ~p, 0);
        check_out("pre_reset", 2, 1, 1, 1);
        n_reset = 1'b0;
        #1;
        check_out("async_reset", 0, 0, 0, 0);
        model_reset();
        @(negedge clk);
        n_reset = 1'b1;

        // Random stream: mostly the true sequence with corruption, resyncs, gaps and clears.
        src = 16'hACE1;
        for (int i = 0; i < 3000; i++) begin
            v = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 199) == 0) src = 16'($urandom_range(1, 65535));
            d = src;
            if ($urandom_range(0, 11) == 0) d = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
            if (v) src = nxt(src);
            drive(v, d, c);
            check_out($sformatf("rnd%0d", i), m_mode, m_mode == 2, m_pulse, m_cnt);
        end
        data_valid = 1'b0;

        // Saturation on the long-flywheel instance.
        w = 16'hACE1;
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b1; s_data = w; tick(); w = nxt(w);
        end
        chk("sat.locked", 32'(s_locked), 1);
        p = w; errs = 0; run = 0;
        while (errs < 65537) begin
            if (run == 254) begin s_data = p; run = 0; end
            else begin s_data = ~p; run++; errs++; end
            tick();
            p = nxt(p);
            if (errs == 65534 && run != 0) chk("sat.preload", 32'(s_count), 32'hFFFE);
        end
        chk("sat.count", 32'(s_count), 32'hFFFF);
        chk("sat.still_locked", 32'(s_locked), 1);
        s_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
